// File: rtl/bram_cmd_executor.sv
// Pops {wr_not_rd, addr, data} commands, runs them on a single-port BRAM and returns read data; EXEC_STATS_EN adds wr/rd/stall counters.
// Latency from pop: write strobe +3, read response push +5; one command in flight, waits in RESP while resp_fifo_full.
module bram_cmd_executor #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cmd_fifo_empty,
   input  logic [ADDR_WIDTH+DATA_WIDTH:0]   cmd_fifo_rd_data,
   output logic                             cmd_fifo_rd_en,
   input  logic                             resp_fifo_full,
   output logic                             resp_fifo_wr_en,
   output logic [DATA_WIDTH-1:0]            resp_fifo_wr_data,
   output logic [ADDR_WIDTH-1:0]            bram_address,
   output logic [DATA_WIDTH-1:0]            bram_data_in,
   input  logic [DATA_WIDTH-1:0]            bram_data_out,
   output logic                             bram_wr_en,
   output logic                             bram_rd_en,
   output logic                             bram_op_done,
   output logic                             busy
`ifdef EXEC_STATS_EN
   ,
   output logic [15:0]                      wr_count,
   output logic [15:0]                      rd_count,
   output logic [15:0]                      stall_count
`endif
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      POP   = 3'd1,
      LATCH = 3'd2,
      EXEC  = 3'd3,
      RWAIT = 3'd4,
      RESP  = 3'd5
   } state_t;

   state_t state, next_state;
   logic   cmd_wr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (!cmd_fifo_empty) next_state = POP;
         POP:     next_state = LATCH;
         LATCH:   next_state = EXEC;
         EXEC:    next_state = cmd_wr ? IDLE : RWAIT;
         RWAIT:   next_state = RESP;
         RESP:    if (!resp_fifo_full) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Strobes are gated by rst so nothing leaks out while reset is held with a non-empty FIFO.
   always_comb begin
      cmd_fifo_rd_en  = 1'b0;
      bram_wr_en      = 1'b0;
      bram_rd_en      = 1'b0;
      resp_fifo_wr_en = 1'b0;
      bram_op_done    = 1'b0;
      busy            = 1'b0;
      if (!rst) begin
         busy = (state != IDLE);
         case (state)
            IDLE: cmd_fifo_rd_en = !cmd_fifo_empty;
            EXEC: begin
               if (cmd_wr) begin
                  bram_wr_en   = 1'b1;
                  bram_op_done = 1'b1;
               end else begin
                  bram_rd_en   = 1'b1;
               end
            end
            RESP: begin
               if (!resp_fifo_full) begin
                  resp_fifo_wr_en = 1'b1;
                  bram_op_done    = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_wr            <= 1'b0;
         bram_address      <= '0;
         bram_data_in      <= '0;
         resp_fifo_wr_data <= '0;
      end else begin
         if (state == LATCH) begin
            cmd_wr       <= cmd_fifo_rd_data[ADDR_WIDTH+DATA_WIDTH];
            bram_address <= cmd_fifo_rd_data[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
            bram_data_in <= cmd_fifo_rd_data[DATA_WIDTH-1:0];
         end
         if (state == RWAIT) begin
            resp_fifo_wr_data <= bram_data_out;
         end
      end
   end

`ifdef EXEC_STATS_EN
   // Saturating event counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_count    <= '0;
         rd_count    <= '0;
         stall_count <= '0;
      end else begin
         if (bram_wr_en && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
         end
         if (resp_fifo_wr_en && (rd_count != 16'hFFFF)) begin
            rd_count <= rd_count + 16'd1;
         end
         if ((state == RESP) && resp_fifo_full && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_bram_cmd_executor.sv
// Directed bench for bram_cmd_executor with behavioural command FIFO, BRAM and response FIFO models.
module tb_bram_cmd_executor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_fifo_empty;
   logic [16:0] cmd_fifo_rd_data = '0;
   logic        cmd_fifo_rd_en;
   logic        resp_fifo_full = 1'b0;
   logic        resp_fifo_wr_en;
   logic [7:0]  resp_fifo_wr_data;
   logic [7:0]  bram_address;
   logic [7:0]  bram_data_in;
   logic [7:0]  bram_data_out = '0;
   logic        bram_wr_en;
   logic        bram_rd_en;
   logic        bram_op_done;
   logic        busy;
`ifdef EXEC_STATS_EN
   logic [15:0] wr_count;
   logic [15:0] rd_count;
   logic [15:0] stall_count;
`endif

   bram_cmd_executor dut (
      .clk               (clk),
      .rst               (rst),
      .cmd_fifo_empty    (cmd_fifo_empty),
      .cmd_fifo_rd_data  (cmd_fifo_rd_data),
      .cmd_fifo_rd_en    (cmd_fifo_rd_en),
      .resp_fifo_full    (resp_fifo_full),
      .resp_fifo_wr_en   (resp_fifo_wr_en),
      .resp_fifo_wr_data (resp_fifo_wr_data),
      .bram_address      (bram_address),
      .bram_data_in      (bram_data_in),
      .bram_data_out     (bram_data_out),
      .bram_wr_en        (bram_wr_en),
      .bram_rd_en        (bram_rd_en),
      .bram_op_done      (bram_op_done),
      .busy              (busy)
`ifdef EXEC_STATS_EN
      ,
      .wr_count          (wr_count),
      .rd_count          (rd_count),
      .stall_count       (stall_count)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Command FIFO storage: written by the stimulus, drained by the model loop.
   logic [16:0] cmd_mem [64];
   int          wp = 0;
   int          rp = 0;
   assign cmd_fifo_empty = (rp == wp);

   logic [7:0]  mem [256];
   int          pop_n = 0, wr_n = 0, resp_n = 0, done_n = 0, both_hi = 0;
   int          pop_cyc [64];
   int          resp_cyc [64];
   logic [7:0]  resp_dat [64];
   int          wr_cyc = 0;
   logic [7:0]  wr_addr = '0, wr_data = '0;
   logic        wr_done = 1'b0;

   // Sample late in the low phase, apply FIFO/BRAM effects just after the rising edge.
   always begin
      logic       s_pop, s_wr, s_rd;
      logic [7:0] s_addr, s_din;
      @(negedge clk);
      #4;
      s_pop  = cmd_fifo_rd_en;
      s_wr   = bram_wr_en;
      s_rd   = bram_rd_en;
      s_addr = bram_address;
      s_din  = bram_data_in;
      if (bram_wr_en && bram_rd_en) both_hi++;
      if (s_pop) begin
         pop_cyc[pop_n] = cyc;
         pop_n++;
      end
      if (s_wr) begin
         wr_n++;
         wr_cyc  = cyc;
         wr_addr = bram_address;
         wr_data = bram_data_in;
         wr_done = bram_op_done;
      end
      if (resp_fifo_wr_en) begin
         resp_dat[resp_n] = resp_fifo_wr_data;
         resp_cyc[resp_n] = cyc;
         resp_n++;
      end
      if (bram_op_done) done_n++;
      @(posedge clk);
      #1;
      if (s_pop) begin
         cmd_fifo_rd_data = cmd_mem[rp];
         rp++;
      end
      if (s_wr) mem[s_addr] = s_din;
      if (s_rd) bram_data_out = mem[s_addr];
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic w, input logic [7:0] a, input logic [7:0] d);
      cmd_mem[wp] = {w, a, d};
      wp++;
   endtask

   task automatic wait_done(input string tag, input int target, input int budget);
      for (int i = 0; i < budget && done_n < target; i++) tick();
      check(tag, done_n, target);
   endtask

   task automatic wait_pop(input string tag, input int target, input int budget);
      for (int i = 0; i < budget && pop_n < target; i++) tick();
      check(tag, pop_n, target);
   endtask

   initial begin
      int b, p, r0;

      // Reset state, with a command already queued to prove the pop strobe is held off.
      repeat (3) tick();
      push_cmd(1'b1, 8'h00, 8'h10);
      tick();
      check("rst_busy",     32'(busy), 0);
      check("rst_rd_en",    32'(cmd_fifo_rd_en), 0);
      check("rst_strobes",  32'({bram_wr_en, bram_rd_en, resp_fifo_wr_en, bram_op_done}), 0);
      check("rst_data",     32'({bram_address, bram_data_in, resp_fifo_wr_data}), 0);
      rst = 1'b0;

      // Single write.
      wait_done("a_done", 1, 40);
      check("a_wr_lat",  wr_cyc - pop_cyc[0], 3);
      check("a_wr_addr", 32'(wr_addr), 32'h00);
      check("a_wr_data", 32'(wr_data), 32'h10);
      check("a_wr_done", 32'(wr_done), 1);
      check("a_no_resp", resp_n, 0);

      // Write then read back.
      push_cmd(1'b1, 8'h05, 8'h24);
      push_cmd(1'b0, 8'h05, 8'h00);
      wait_done("b_done", 3, 60);
      check("b_rd_data", 32'(resp_dat[0]), 32'h24);
      check("b_rd_lat",  resp_cyc[0] - pop_cyc[2], 5);
      check("b_hold",    32'({bram_address, bram_data_in}), 32'h0500);

      // Sixteen writes then sixteen reads.
      b  = pop_n;
      r0 = resp_n;
      for (int i = 0; i < 16; i++) push_cmd(1'b1, 8'(i), 8'(8'h10 + 4 * i));
      for (int i = 0; i < 16; i++) push_cmd(1'b0, 8'(i), 8'h00);
      wait_done("c_done", done_n + 32, 600);
      check("c_resp_n", resp_n - r0, 16);
      for (int i = 0; i < 16; i++) check($sformatf("c_rd%0d", i), 32'(resp_dat[r0 + i]), 32'h10 + 4 * i);
      check("c_wr_gap", pop_cyc[b + 1] - pop_cyc[b], 4);
      check("c_rd_gap", pop_cyc[b + 17] - pop_cyc[b + 16], 6);

      // Response FIFO full for seven RESP cycles.
      resp_fifo_full = 1'b1;
      b  = pop_n;
      r0 = resp_n;
      push_cmd(1'b0, 8'h05, 8'h00);
      wait_pop("d_pop", b + 1, 40);
      p = pop_cyc[b];
      while (cyc < p + 8) tick();
      check("d_stall_busy", 32'(busy), 1);
      check("d_stall_wen",  32'(resp_fifo_wr_en), 0);
      check("d_stall_dat",  32'(resp_fifo_wr_data), 32'h24);
      while (cyc < p + 12) tick();
      check("d_held_dat",   32'(resp_fifo_wr_data), 32'h24);
      resp_fifo_full = 1'b0;
      wait_done("d_done", done_n + 1, 40);
      check("d_push_lat",   resp_cyc[r0] - p, 12);
      check("d_push_dat",   32'(resp_dat[r0]), 32'h24);
`ifdef EXEC_STATS_EN
      check("d_stall_cnt",  32'(stall_count), 7);
      check("d_rd_cnt",     32'(rd_count), 18);
`endif

      // Reset during RWAIT, then a command queued under reset runs normally.
      b  = pop_n;
      r0 = resp_n;
      push_cmd(1'b0, 8'h05, 8'h00);
      wait_pop("e_pop", b + 1, 40);
      p = pop_cyc[b];
      while (cyc < p + 4) tick();
      rst = 1'b1;
      tick();
      check("e_busy",    32'(busy), 0);
      check("e_strobes", 32'({bram_wr_en, bram_rd_en, resp_fifo_wr_en, bram_op_done}), 0);
      check("e_rdata",   32'(resp_fifo_wr_data), 0);
      push_cmd(1'b1, 8'h07, 8'h5A);
      tick();
      check("e_no_pop",  32'(cmd_fifo_rd_en), 0);
      rst = 1'b0;
      wait_done("e_done", done_n + 1, 40);
      check("e_wr_addr", 32'(wr_addr), 32'h07);
      check("e_wr_data", 32'(wr_data), 32'h5A);
      check("e_wr_lat",  wr_cyc - pop_cyc[b + 1], 3);
      check("e_no_resp", resp_n - r0, 0);
`ifdef EXEC_STATS_EN
      check("e_wr_cnt",  32'(wr_count), 1);
`endif
      check("both_strobes", both_hi, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
